// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined ALU: opcodes, flag bit positions, FSM states.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SHL  = 4'b0101;
    localparam logic [3:0] OP_SHR  = 4'b0110;
    localparam logic [3:0] OP_MUL  = 4'b0111;
    localparam logic [3:0] OP_LOAD = 4'b1110;

    localparam int FLAG_CARRY = 3;
    localparam int FLAG_NEG   = 2;
    localparam int FLAG_ZERO  = 1;
    localparam int FLAG_ILL   = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // Assemble the flag nibble so every bit is written on every completed op.
    function automatic logic [3:0] pack_flags(input logic carry, input logic neg,
                                              input logic zero, input logic ill);
        logic [3:0] f;
        f             = 4'b0000;
        f[FLAG_CARRY] = carry;
        f[FLAG_NEG]   = neg;
        f[FLAG_ZERO]  = zero;
        f[FLAG_ILL]   = ill;
        return f;
    endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Sequential shift-add multiplier: one partial product per cycle, WIDTH cycles per op.
module alu_mul_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_next_s;

    // Next-state of the shift-add engine; the final sum is exposed combinationally
    // so the caller can register it on the same edge as the last iteration.
    always_comb begin
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        acc_next_s = acc_q + (mplier_q[0] ? mcand_q : {(2*WIDTH){1'b0}});
        if (start) begin
            mcand_d  = {{WIDTH{1'b0}}, a};
            mplier_d = b;
            acc_d    = {(2*WIDTH){1'b0}};
            cnt_d    = CW'(WIDTH);
        end else if (cnt_q != {CW{1'b0}}) begin
            mcand_d  = {mcand_q[2*WIDTH-2:0], 1'b0};
            mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
            acc_d    = acc_next_s;
            cnt_d    = cnt_q - CW'(1);
        end else begin
            cnt_d    = cnt_q;
        end
    end

    // Engine registers; reset clears count and accumulator, aborting any op.
    always_ff @(posedge clk) begin
        if (reset) begin
            mcand_q  <= {(2*WIDTH){1'b0}};
            mplier_q <= {WIDTH{1'b0}};
            acc_q    <= {(2*WIDTH){1'b0}};
            cnt_q    <= {CW{1'b0}};
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end

    // Status decode: done marks the cycle whose edge performs the last iteration.
    always_comb begin
        busy    = (cnt_q != {CW{1'b0}});
        done    = (cnt_q == CW'(1));
        product = acc_next_s;
    end

endmodule

// File: rtl/alu_pipe.sv
// ALU with valid/ready handshakes: single-cycle ops finish in one cycle,
// MUL runs on a sequential multiplier, result held until taken.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int MUL_EN = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] load_number,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic [3:0]       flag
);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   out_q, out_d;
    logic [3:0]         flag_q, flag_d;
    logic [WIDTH-1:0]   alu_res_s;
    logic [3:0]         alu_flag_s;
    logic [WIDTH:0]     sum_s;
    logic               carry_s, neg_s, ill_s;
    logic               is_mul_s, mul_start_s, mul_busy_s, mul_done_s;
    logic [2*WIDTH-1:0] mul_prod_s;

    generate
        if (MUL_EN != 0) begin : g_mul
            alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
                .clk     (clk),
                .reset   (reset),
                .start   (mul_start_s),
                .a       (a),
                .b       (b),
                .busy    (mul_busy_s),
                .done    (mul_done_s),
                .product (mul_prod_s)
            );
        end else begin : g_no_mul
            assign mul_busy_s = 1'b0;
            assign mul_done_s = 1'b0;
            assign mul_prod_s = {(2*WIDTH){1'b0}};
        end
    endgenerate

    // Single-cycle datapath from the operands presented at acceptance.
    always_comb begin
        sum_s     = {1'b0, a} + {1'b0, b};
        alu_res_s = {WIDTH{1'b0}};
        carry_s   = 1'b0;
        ill_s     = 1'b0;
        case (opcode)
            OP_ADD: begin
                alu_res_s = sum_s[WIDTH-1:0];
                carry_s   = sum_s[WIDTH];
            end
            OP_SUB:  alu_res_s = a - b;
            OP_AND:  alu_res_s = a & b;
            OP_OR:   alu_res_s = a | b;
            OP_XOR:  alu_res_s = a ^ b;
            OP_SHL: begin
                alu_res_s = {a[WIDTH-2:0], 1'b0};
                carry_s   = a[WIDTH-1];
            end
            OP_SHR: begin
                alu_res_s = {1'b0, a[WIDTH-1:1]};
                carry_s   = a[0];
            end
            OP_LOAD: alu_res_s = load_number;
            default: ill_s = 1'b1;
        endcase
        if (opcode == OP_SUB) begin
            neg_s = (a < b);
        end else begin
            neg_s = alu_res_s[WIDTH-1];
        end
        if (ill_s) begin
            alu_flag_s = pack_flags(1'b0, 1'b0, 1'b0, 1'b1);
        end else begin
            alu_flag_s = pack_flags(carry_s, neg_s, (alu_res_s == {WIDTH{1'b0}}), 1'b0);
        end
        is_mul_s = (MUL_EN != 0) && (opcode == OP_MUL);
    end

    // Next-state and result capture; MUL opcode falls into illegal path when disabled.
    always_comb begin
        state_d     = state_q;
        out_d       = out_q;
        flag_d      = flag_q;
        mul_start_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    if (is_mul_s) begin
                        state_d     = ST_MUL;
                        mul_start_s = 1'b1;
                    end else begin
                        state_d = ST_DONE;
                        out_d   = alu_res_s;
                        flag_d  = alu_flag_s;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MUL: begin
                if (mul_done_s) begin
                    state_d = ST_DONE;
                    out_d   = mul_prod_s[WIDTH-1:0];
                    flag_d  = pack_flags(|mul_prod_s[2*WIDTH-1:WIDTH],
                                         mul_prod_s[WIDTH-1],
                                         (mul_prod_s[WIDTH-1:0] == {WIDTH{1'b0}}),
                                         1'b0);
                end else if (!mul_busy_s) begin
                    // Multiplier lost its operation; recover rather than hang.
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_MUL;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and result registers; reset wins over any acceptance on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            out_q   <= {WIDTH{1'b0}};
            flag_q  <= 4'b0000;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            flag_q  <= flag_d;
        end
    end

    // Handshake outputs decoded from the registered state.
    always_comb begin
        in_ready  = (state_q == ST_IDLE);
        out_valid = (state_q == ST_DONE);
        out       = out_q;
        flag      = flag_q;
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed self-checking bench for alu_pipe at WIDTH=8.
module tb_alu_pipe;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] opcode;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] load_number;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out;
    logic [3:0] flag;

    int n_checks = 0;
    int n_pass   = 0;

    alu_pipe #(.WIDTH(8), .MUL_EN(1)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .opcode      (opcode),
        .a           (a),
        .b           (b),
        .load_number (load_number),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out         (out),
        .flag        (flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request, wait for the result, optionally stall, then take it.
    task automatic do_op(input string tag, input logic [3:0] op, input logic [7:0] av,
                         input logic [7:0] bv, input logic [7:0] ld,
                         input logic [7:0] exp_out, input logic [3:0] exp_flag,
                         input int exp_lat, input int hold);
        int lat;
        logic [7:0] o0;
        logic [3:0] f0;
        check_eq({tag, "_ready_idle"}, {31'd0, in_ready}, 32'd1);
        in_valid    = 1'b1;
        opcode      = op;
        a           = av;
        b           = bv;
        load_number = ld;
        tick();
        in_valid    = 1'b0;
        opcode      = 4'b0000;
        a           = 8'($urandom);
        b           = 8'($urandom);
        load_number = 8'($urandom);
        lat = 1;
        while (!out_valid && lat < 40) begin
            check_eq({tag, "_ready_busy"}, {31'd0, in_ready}, 32'd0);
            tick();
            lat++;
        end
        check_eq({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check_eq({tag, "_out"}, {24'd0, out}, {24'd0, exp_out});
        check_eq({tag, "_flag"}, {28'd0, flag}, {28'd0, exp_flag});
        o0 = out;
        f0 = flag;
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            opcode   = 4'b0000;
            a        = 8'h11;
            b        = 8'h22;
            tick();
            check_eq({tag, "_hold_valid"}, {31'd0, out_valid}, 32'd1);
            check_eq({tag, "_hold_out"}, {24'd0, out}, {24'd0, o0});
            check_eq({tag, "_hold_flag"}, {28'd0, flag}, {28'd0, f0});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_eq({tag, "_drained"}, {31'd0, out_valid}, 32'd0);
        check_eq({tag, "_keep_out"}, {24'd0, out}, {24'd0, exp_out});
    endtask

    initial begin
        int seen;
        reset       = 1'b1;
        in_valid    = 1'b0;
        opcode      = 4'b0000;
        a           = 8'h00;
        b           = 8'h00;
        load_number = 8'h00;
        out_ready   = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        check_eq("rst_ready", {31'd0, in_ready}, 32'd1);
        check_eq("rst_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst_out", {24'd0, out}, 32'd0);
        check_eq("rst_flag", {28'd0, flag}, 32'd0);

        do_op("add",   4'b0000, 8'hF0, 8'h20, 8'h00, 8'h10, 4'b1000, 1, 0);
        do_op("sub_eq",4'b0001, 8'h05, 8'h05, 8'h00, 8'h00, 4'b0010, 1, 0);
        do_op("sub_lt",4'b0001, 8'h03, 8'h05, 8'h00, 8'hFE, 4'b0100, 1, 0);
        do_op("and",   4'b0010, 8'hF0, 8'h3C, 8'h00, 8'h30, 4'b0000, 1, 0);
        do_op("or",    4'b0011, 8'h0F, 8'hF0, 8'h00, 8'hFF, 4'b0100, 1, 0);
        do_op("xor",   4'b0100, 8'hAA, 8'hAA, 8'h00, 8'h00, 4'b0010, 1, 0);
        do_op("shl",   4'b0101, 8'h80, 8'h00, 8'h00, 8'h00, 4'b1010, 1, 0);
        do_op("shr",   4'b0110, 8'h81, 8'h00, 8'h00, 8'h40, 4'b1000, 1, 0);
        do_op("load",  4'b1110, 8'h00, 8'h00, 8'h9C, 8'h9C, 4'b0100, 1, 0);
        do_op("mul",   4'b0111, 8'h10, 8'h11, 8'h00, 8'h10, 4'b1000, 9, 0);
        do_op("mul_ff",4'b0111, 8'hFF, 8'hFF, 8'h00, 8'h01, 4'b1000, 9, 0);
        do_op("mul_0", 4'b0111, 8'h00, 8'h37, 8'h00, 8'h00, 4'b0010, 9, 0);
        do_op("ill_a", 4'b1010, 8'h12, 8'h34, 8'h56, 8'h00, 4'b0001, 1, 5);
        do_op("ill_f", 4'b1111, 8'hFF, 8'hFF, 8'hFF, 8'h00, 4'b0001, 1, 0);

        // Put a nonzero result in the output register, then abort a MUL with reset.
        do_op("pre",   4'b1110, 8'h00, 8'h00, 8'h9C, 8'h9C, 4'b0100, 1, 0);
        in_valid = 1'b1;
        opcode   = 4'b0111;
        a        = 8'h10;
        b        = 8'h11;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("abort_ready", {31'd0, in_ready}, 32'd1);
        check_eq("abort_valid", {31'd0, out_valid}, 32'd0);
        check_eq("abort_out", {24'd0, out}, 32'd0);
        check_eq("abort_flag", {28'd0, flag}, 32'd0);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (out_valid) seen++;
        end
        check_eq("abort_no_valid", 32'(seen), 32'd0);

        // Reset and a request on the same edge: reset wins.
        reset       = 1'b1;
        in_valid    = 1'b1;
        opcode      = 4'b1110;
        load_number = 8'h5A;
        tick();
        reset    = 1'b0;
        in_valid = 1'b0;
        check_eq("rst_prio_ready", {31'd0, in_ready}, 32'd1);
        check_eq("rst_prio_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst_prio_out", {24'd0, out}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand/result width in bits (legal values 4..32).
REQ-002 The block SHALL have parameter MUL_EN, default 1, which enables the MUL opcode (0 = MUL treated as illegal).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  request present on opcode/a/b/load_number.
REQ-006 in_ready  output  1  block can accept a request this cycle.
REQ-007 opcode  input  4  operation select (see REQ-012).
REQ-008 a, b  input  WIDTH each  operands.
REQ-009 load_number  input  WIDTH  immediate for LOAD.
REQ-010 out_valid / out_ready  output / input  1 each  result handshake.
REQ-011 out  output  WIDTH  result; flag  output  4  {carry, negative, zero, illegal} at bits [3:0].

Function
REQ-012 Opcodes SHALL be: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SHL by 1, 0110 SHR by 1 (logical), 0111 MUL, 1110 LOAD; all others illegal.
REQ-013 A request SHALL be accepted on a cycle where in_valid and in_ready are both 1; operands are captured into internal registers at acceptance.
REQ-014 FSM states SHALL be IDLE, MUL, DONE; in_ready is 1 only in IDLE.
REQ-015 IDLE + accept of non-MUL opcode -> DONE, result and flags registered at that edge; out_valid=1 the next cycle (latency 1).
REQ-016 IDLE + accept of MUL -> MUL; shift-add runs exactly WIDTH cycles, then -> DONE (out_valid asserted WIDTH+1 cycles after acceptance).
REQ-017 DONE SHALL hold out_valid=1 and out/flag stable until out_ready=1, then -> IDLE; out/flag keep their last value afterwards.
REQ-018 No new request is accepted in the cycle DONE is left; back-to-back throughput is one op per 2 cycles minimum.
REQ-019 ADD: out = (a+b) mod 2^WIDTH; carry = bit WIDTH of the WIDTH+1-bit sum.
REQ-020 SUB: out = (a-b) mod 2^WIDTH; carry = 0; negative = 1 when a<b (unsigned).
REQ-021 SHL: carry = a[WIDTH-1]; SHR: carry = a[0]; AND/OR/XOR/LOAD: carry = 0.
REQ-022 MUL: out = low WIDTH bits of unsigned a*b; carry = 1 when the high WIDTH bits are non-zero.
REQ-023 For every opcode except SUB, negative = out[WIDTH-1].
REQ-024 zero = 1 exactly when out == 0, for every legal opcode.
REQ-025 Illegal opcode: out = 0, flag = 4'b0001, latency 1; every flag bit is written on every completed op (no stale bits).
REQ-026 Inputs opcode/a/b/load_number SHALL be ignored while in_ready=0.

Reset
REQ-027 reset=1 at a clock edge SHALL force state IDLE, out=0, flag=0, out_valid=0, multiplier count/accumulator=0; in_ready=1 the cycle after.
REQ-028 reset during MUL or DONE SHALL abort the operation; no out_valid is produced for it.
REQ-029 reset SHALL take priority over acceptance in the same cycle.

Structure
REQ-030 A shared package alu_pkg SHALL hold opcode constants, flag bit index constants, and the FSM state enum.
REQ-031 The multiplier SHALL be a sub-module alu_mul_seq (start, busy, done, WIDTH-parameterised, 2*WIDTH product) instantiated only when MUL_EN=1.
REQ-032 Datapath for single-cycle ops SHALL be purely combinational from captured operands into the result register.

Verification (WIDTH=8)
REQ-033 ADD a=8'hF0 b=8'h20 -> out=8'h10, flag=4'b1000, out_valid 1 cycle after accept.
REQ-034 SUB a=8'h05 b=8'h05 -> out=0, flag=4'b0010; SUB a=3 b=5 -> out=8'hFE, flag=4'b0100.
REQ-035 MUL a=8'h10 b=8'h11 -> out=8'h10, flag=4'b1000, out_valid exactly 9 cycles after accept; in_ready=0 throughout.
REQ-036 out_ready held 0 for 5 cycles in DONE -> out/flag/out_valid stable; opcode 1010 -> out=0, flag=4'b0001.
REQ-037 reset asserted 3 cycles into a MUL -> out_valid never rises for it, out=0, flag=0, in_ready=1 next cycle.
REQ-038 SHL a=8'h80 -> out=0, flag=4'b1010; LOAD load_number=8'h9C -> out=8'h9C, flag=4'b0100.
